// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, derived totals/sync windows and sync polarity encoding.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int unsigned H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int unsigned V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Narrowest width that can hold total-1.
  function automatic int unsigned axis_width(input int unsigned total);
    return (total < 3) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and a next-position visible flag.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE  = H_VISIBLE_DEF,
  parameter int unsigned FRONT    = H_FRONT_DEF,
  parameter int unsigned SYNC     = H_SYNC_DEF,
  parameter int unsigned BACK     = H_BACK_DEF,
  parameter bit          SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int unsigned W        = axis_width(VISIBLE + FRONT + SYNC + BACK)
) (
  input  logic         pixelclock,
  input  logic         nreset,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync,
  output logic         active
);

  localparam int unsigned TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam int unsigned SYNC_START = VISIBLE + FRONT;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;

  logic [W-1:0] count_q, count_d;
  logic         sync_q, sync_d;
  logic [31:0]  count_ext;

  assign wrap = (count_q == W'(TOTAL - 1));

  always_comb begin
    count_d = count_q;
    if (tick) count_d = wrap ? '0 : count_q + W'(1);
  end

  // Decode the position being loaded so sync and active line up with the counter register.
  always_comb begin
    count_ext = 32'(count_d);
    sync_d    = ((count_ext >= SYNC_START) && (count_ext < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    active    = (count_ext < VISIBLE);
  end

  always_ff @(posedge pixelclock or negedge nreset) begin
    if (!nreset) begin
      count_q <= '0;
      sync_q  <= ~SYNC_POL;
    end else if (tick) begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator (hsinc/vsinc/draw/h_count/v_count), advancing on pix_en.
// Optional frame_start/frame_cnt outputs when VGA_FRAME_CNT_EN is defined.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter bit          SYNC_POL  = SYNC_ACTIVE_LOW,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             pixelclock,
  input  logic             nreset,
  input  logic             pix_en,
  output logic             hsinc,
  output logic             vsinc,
  output logic             draw,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
`endif
);

  localparam int unsigned HW = axis_width(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam int unsigned VW = axis_width(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, v_wrap, h_act, v_act, v_tick;
  logic          draw_q, draw_d;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .SYNC_POL(SYNC_POL),
    .W       (HW)
  ) u_h_axis (
    .pixelclock(pixelclock),
    .nreset    (nreset),
    .tick      (pix_en),
    .count     (h_cnt),
    .wrap      (h_wrap),
    .sync      (hsinc),
    .active    (h_act)
  );

  assign v_tick = h_wrap & pix_en;

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .SYNC_POL(SYNC_POL),
    .W       (VW)
  ) u_v_axis (
    .pixelclock(pixelclock),
    .nreset    (nreset),
    .tick      (v_tick),
    .count     (v_cnt),
    .wrap      (v_wrap),
    .sync      (vsinc),
    .active    (v_act)
  );

  // Reset value 0 blanks position (0,0) of the first frame after reset.
  always_comb begin
    draw_d = draw_q;
    if (pix_en) draw_d = h_act & v_act;
  end

  always_ff @(posedge pixelclock or negedge nreset) begin
    if (!nreset) draw_q <= 1'b0;
    else         draw_q <= draw_d;
  end

  assign draw    = draw_q;
  assign h_count = CNT_W'(h_cnt);
  assign v_count = CNT_W'(v_cnt);

`ifdef VGA_FRAME_CNT_EN
  logic       frame_tick;
  logic       frame_start_q;
  logic [7:0] frame_cnt_q;

  assign frame_tick = pix_en & h_wrap & v_wrap;

  always_ff @(posedge pixelclock or negedge nreset) begin
    if (!nreset) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= frame_tick;
      if (frame_tick) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, inverted polarity and a reduced-size raster.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic nreset;
  logic pix_en;

  always #5 clk = ~clk;

  logic        d_hs, d_vs, d_draw;
  logic [15:0] d_h, d_v;
  logic        p_hs, p_vs, p_draw;
  logic [15:0] p_h, p_v;
  logic        s_hs, s_vs, s_draw;
  logic [7:0]  s_h, s_v;
`ifdef VGA_FRAME_CNT_EN
  logic        d_fs, p_fs, s_fs;
  logic [7:0]  d_fc, p_fc, s_fc;
`endif

  vga_sync_gen dut (
    .pixelclock(clk), .nreset(nreset), .pix_en(pix_en),
    .hsinc(d_hs), .vsinc(d_vs), .draw(d_draw), .h_count(d_h), .v_count(d_v)
`ifdef VGA_FRAME_CNT_EN
    , .frame_start(d_fs), .frame_cnt(d_fc)
`endif
  );

  vga_sync_gen #(.SYNC_POL(1'b1)) dut_p (
    .pixelclock(clk), .nreset(nreset), .pix_en(pix_en),
    .hsinc(p_hs), .vsinc(p_vs), .draw(p_draw), .h_count(p_h), .v_count(p_v)
`ifdef VGA_FRAME_CNT_EN
    , .frame_start(p_fs), .frame_cnt(p_fc)
`endif
  );

  // 10 x 7 raster: hsync low for h 6..8, vsync low for v 4..5, 70 ticks per frame.
  vga_sync_gen #(
    .H_VISIBLE(4), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CNT_W(8)
  ) dut_s (
    .pixelclock(clk), .nreset(nreset), .pix_en(pix_en),
    .hsinc(s_hs), .vsinc(s_vs), .draw(s_draw), .h_count(s_h), .v_count(s_v)
`ifdef VGA_FRAME_CNT_EN
    , .frame_start(s_fs), .frame_cnt(s_fc)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;
  int k      = 0;
  int cyc    = 0;
  bit fresh  = 1'b1;
  bit ticked = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (tick %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic check_all();
    int h, v, hs, vs, dr, sh, sv, shs, svs, sdr;
    h   = k % 800;
    v   = (k / 800) % 525;
    hs  = (h >= 656 && h < 752) ? 0 : 1;
    vs  = (v >= 490 && v < 492) ? 0 : 1;
    dr  = (!fresh && h < 640 && v < 480) ? 1 : 0;
    sh  = k % 10;
    sv  = (k / 10) % 7;
    shs = (sh >= 6 && sh < 9) ? 0 : 1;
    svs = (sv >= 4 && sv < 6) ? 0 : 1;
    sdr = (!fresh && sh < 4 && sv < 3) ? 1 : 0;
    chk("dut.h_count", 32'(d_h), h);
    chk("dut.v_count", 32'(d_v), v);
    chk("dut.hsinc", 32'(d_hs), hs);
    chk("dut.vsinc", 32'(d_vs), vs);
    chk("dut.draw", 32'(d_draw), dr);
    chk("pol1.hsinc", 32'(p_hs), 1 - hs);
    chk("pol1.vsinc", 32'(p_vs), 1 - vs);
    chk("pol1.draw", 32'(p_draw), dr);
    chk("pol1.h_count", 32'(p_h), h);
    chk("small.h_count", 32'(s_h), sh);
    chk("small.v_count", 32'(s_v), sv);
    chk("small.hsinc", 32'(s_hs), shs);
    chk("small.vsinc", 32'(s_vs), svs);
    chk("small.draw", 32'(s_draw), sdr);
`ifdef VGA_FRAME_CNT_EN
    chk("small.frame_start", 32'(s_fs), (ticked && k > 0 && k % 70 == 0) ? 1 : 0);
    chk("small.frame_cnt", 32'(s_fc), (k / 70) % 256);
    chk("dut.frame_start", 32'(d_fs), (ticked && k > 0 && k % 420000 == 0) ? 1 : 0);
    chk("dut.frame_cnt", 32'(d_fc), (k / 420000) % 256);
`endif
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    #1;
    cyc++;
    ticked = en;
    if (en) begin
      k++;
      fresh = 1'b0;
    end
    check_all();
  endtask

  initial begin
    int hs_low, hs_rise, fall_n, nframes, fs_seen;
    int fall_cyc[2];
    logic prev_hs;

    nreset = 1'b0;
    pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst.dut.hsinc", 32'(d_hs), 1);
    chk("rst.dut.vsinc", 32'(d_vs), 1);
    chk("rst.dut.draw", 32'(d_draw), 0);
    chk("rst.pol1.hsinc", 32'(p_hs), 0);
    nreset = 1'b1;

    // One full line at full rate.
    hs_low  = 0;
    hs_rise = 0;
    prev_hs = d_hs;
    for (int i = 0; i < 800; i++) begin
      step(1'b1);
      if (d_hs === 1'b0) hs_low++;
      if (prev_hs === 1'b0 && d_hs === 1'b1) hs_rise++;
      prev_hs = d_hs;
      if (k == 1)   chk("first_tick.h_count", 32'(d_h), 1);
      if (k == 655) chk("h655.hsinc", 32'(d_hs), 1);
      if (k == 656) chk("h656.hsinc", 32'(d_hs), 0);
      if (k == 751) chk("h751.hsinc", 32'(d_hs), 0);
      if (k == 752) chk("h752.hsinc", 32'(d_hs), 1);
      if (k == 639) chk("h639.draw", 32'(d_draw), 1);
      if (k == 640) chk("h640.draw", 32'(d_draw), 0);
    end
    chk("line.hsinc_low_clocks", hs_low, 96);
    chk("line.hsinc_rising_edges", hs_rise, 1);
    chk("line_wrap.v_count", 32'(d_v), 1);
    chk("line_wrap.h_count", 32'(d_h), 0);

    // Half-rate strobe over two lines.
    fall_n  = 0;
    prev_hs = d_hs;
    for (int i = 0; i < 3200; i++) begin
      step((i % 2) == 0);
      if (prev_hs === 1'b1 && d_hs === 1'b0 && fall_n < 2) begin
        fall_cyc[fall_n] = cyc;
        fall_n++;
      end
      prev_hs = d_hs;
    end
    chk("halfrate.hsinc_falls", fall_n, 2);
    if (fall_n == 2) chk("halfrate.line_period", fall_cyc[1] - fall_cyc[0], 1600);
    chk("halfrate.end.v_count", 32'(d_v), 3);

    // Mid-frame asynchronous reset.
    for (int i = 0; i < 305; i++) step(1'b1);
    chk("pre_rst.dut.h_count", 32'(d_h), 305);
    chk("pre_rst.small.vsinc", 32'(s_vs), 0);
    nreset = 1'b0;
    #2;
    k     = 0;
    fresh = 1'b1;
    ticked = 1'b0;
    chk("async_rst.dut.h_count", 32'(d_h), 0);
    chk("async_rst.dut.v_count", 32'(d_v), 0);
    chk("async_rst.dut.hsinc", 32'(d_hs), 1);
    chk("async_rst.dut.vsinc", 32'(d_vs), 1);
    chk("async_rst.dut.draw", 32'(d_draw), 0);
    chk("async_rst.small.vsinc", 32'(s_vs), 1);
    check_all();
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    nreset = 1'b1;
    step(1'b1);
    chk("post_rst.h_count", 32'(d_h), 1);

    // Whole frames on the reduced raster.
`ifdef VGA_FRAME_CNT_EN
    nframes = 256;
`else
    nframes = 3;
`endif
    fs_seen = 0;
    while (k < nframes * 70) begin
      step(1'b1);
`ifdef VGA_FRAME_CNT_EN
      if (s_fs === 1'b1) fs_seen++;
      if (k == 255 * 70) chk("frame255.frame_cnt", 32'(s_fc), 255);
      if (k == 256 * 70) chk("frame256.frame_cnt_wrap", 32'(s_fc), 0);
`endif
      if (k == 70) begin
        chk("frame_end.small.h_count", 32'(s_h), 0);
        chk("frame_end.small.v_count", 32'(s_v), 0);
      end
    end
`ifdef VGA_FRAME_CNT_EN
    chk("frame_start_pulses", fs_seen, 256);
`else
    chk("frames_unused_counter", fs_seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

- Generates 640x480@60 VGA raster timing from the pixel clock: hsinc, vsinc, draw (display-enable), plus the current column/row.
- Sits directly upstream of the digit-plotting stage, which consumes hsinc/vsinc/draw and counts pixels against them.
- Also drives the monitor's sync pins.
- Counters advance only on a pixel-enable tick, so the block runs from a 25 MHz clock (pix_en tied high) or from a 50 MHz clock with a divide-by-2 strobe.

## Interface

Parameters:
- H_VISIBLE, 640, visible columns
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible rows
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- SYNC_POL, 0, asserted level of hsinc/vsinc (0 = active-low)
- CNT_W, 16, counter output width

Ports:
- pixelclock  in  1  pixel clock; all logic on its rising edge
- nreset  in  1  reset. **Asynchronous, active-low.**
- pix_en  in  1  advance-one-pixel strobe
- hsinc  out  1  horizontal sync
- vsinc  out  1  vertical sync
- draw  out  1  high while (h_count, v_count) is in the visible area
- h_count  out  CNT_W  current column, 0..H_TOTAL-1
- v_count  out  CNT_W  current row, 0..V_TOTAL-1

## Operation

- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default); V_TOTAL likewise (525 by default).
- On each cycle with pix_en=1:
  - h_count increments.
  - At H_TOTAL-1 it wraps to 0, and v_count increments.
  - v_count wraps to 0 when it is at V_TOTAL-1 and h_count wraps.
- With pix_en=0 all outputs hold.
- Decode, evaluated on the counter values being loaded:
  - draw = (h < H_VISIBLE) && (v < V_VISIBLE).
  - hsinc = SYNC_POL when H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC, else ~SYNC_POL.
  - vsinc = SYNC_POL when V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC, else ~SYNC_POL.
- All outputs are registered; no combinational path from pix_en to any output.
- Counter arithmetic is unsigned, internally sized to hold H_TOTAL-1/V_TOTAL-1, then zero-extended to CNT_W.
- vsinc changes only on the tick where h_count wraps to 0.

## Timing

- Reset values: h_count=0, v_count=0, hsinc=~SYNC_POL, vsinc=~SYNC_POL, draw=0.
  - The draw=0 at reset is deliberate: position (0,0) of the first frame after reset is blanked.
- Latency: outputs reflect a new position in the cycle after the pix_en tick, and are mutually aligned (same register stage).
- Reset asserted mid-frame: all outputs go to reset values immediately, without waiting for a clock. The first pix_en tick after release loads h_count=1.
- With pix_en tied high:
  - hsinc period is 800 clocks, asserted for 96 clocks starting at h_count=656.
  - vsinc is asserted for 2 lines starting at v_count=490.
- With default parameters, the hsinc deassertion edge (rising, for active-low) occurs exactly once per line. Downstream counts rows on that edge.

## Configuration

- Macro: VGA_FRAME_CNT_EN.
- Defined: adds two ports.
  - frame_start  out  1: one pixelclock-cycle pulse registered in the cycle the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - frame_cnt  out  8: increments on that same tick and wraps 255→0.
  - Both reset to 0.
- Undefined: neither port exists and no frame logic is built. hsinc/vsinc/draw/h_count/v_count behaviour is identical either way.

## Structure

- Shared package vga_timing_pkg holds:
  - default 640x480 timing constants;
  - derived H_TOTAL/V_TOTAL;
  - sync-start/sync-end localparams;
  - the SYNC_POL encoding.
- One sub-module, vga_axis_counter, instantiated twice (horizontal, vertical):
  - parameters VISIBLE/FRONT/SYNC/BACK;
  - inputs tick and nreset;
  - outputs count, wrap, sync, active.
- The horizontal instance's wrap, ANDed with pix_en, is the vertical instance's tick.

## Test plan

- Reset asserted mid-line (h_count=300, v_count=100), no clock → h_count=0, v_count=0, hsinc=1, vsinc=1, draw=0 immediately.
- pix_en high for 800 cycles after reset:
  - hsinc low exactly for h_count 656..751;
  - draw high for h_count 0..639 (except the reset position);
  - v_count becomes 1 when h_count wraps.
- Full frame (420000 ticks):
  - vsinc low only for v_count 490..491;
  - draw low for all v_count ≥ 480;
  - counters return to (0,0).
- pix_en toggling every other cycle → every output holds on pix_en=0 cycles; line period is 1600 clocks.
- SYNC_POL=1 → hsinc/vsinc inverted relative to the default run; draw/counters unchanged.
- VGA_FRAME_CNT_EN defined:
  - frame_start pulses once per 420000 ticks, for one cycle;
  - frame_cnt wraps 255→0 on the 256th frame.
